// File: rtl/mem_responder.sv
// mem_responder: line-burst read / single-word store responder; define MEM_RESP_WAIT_EN to insert WAIT_CYCLES wait states
module mem_responder #(
    parameter int LINE_WORDS  = 4,
    parameter int DEPTH_LOG   = 12,
    parameter int WAIT_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memory_valid,
    input  logic        memory_for_store,
    input  logic [31:0] load_store_addr,
    input  logic [31:0] data_to_mem,
    output logic        memory_ready,
    output logic        memory_last,
    output logic [31:0] data_from_mem
);
    localparam int LW = $clog2(LINE_WORDS);
    localparam logic [LW:0] LAST_CNT = (LW + 1)'(LINE_WORDS);
    typedef enum logic [2:0] {IDLE, WAIT, BURST, STORE, DONE} state_t;
    state_t               state_q, state_d, run_state;
    logic [LW:0]          cnt_q, cnt_d;
    logic [DEPTH_LOG-1:0] idx_q, idx_d, rd_idx;
    logic [31:0]          data_q, data_d, rdata_q;
    logic                 store_q, store_d, beat, unused_addr;
    logic [31:0]          mem [2**DEPTH_LOG];
`ifdef MEM_RESP_WAIT_EN
    localparam int WW = $clog2(WAIT_CYCLES) + 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_CYCLES - 1);
    logic [WW-1:0] wcnt_q, wcnt_d;
`endif
    assign unused_addr = ^{load_store_addr[31:DEPTH_LOG+2], load_store_addr[1:0]};
    assign run_state = store_q ? STORE : BURST;
    assign rd_idx = {idx_q[DEPTH_LOG-1:LW], cnt_q[LW-1:0]};
    assign beat = state_q == BURST && cnt_q != '0;
    assign memory_ready = !rst && (beat || state_q == STORE);
    assign memory_last = !rst && ((state_q == BURST && cnt_q == LAST_CNT) || state_q == STORE);
    assign data_from_mem = (!rst && beat) ? rdata_q : 32'd0;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        store_d = store_q;
`ifdef MEM_RESP_WAIT_EN
        wcnt_d  = wcnt_q;
`endif
        case (state_q)
            IDLE: if (memory_valid) begin
                idx_d   = load_store_addr[DEPTH_LOG+1:2];
                data_d  = data_to_mem;
                store_d = memory_for_store;
                cnt_d   = '0;
`ifdef MEM_RESP_WAIT_EN
                wcnt_d  = '0;
                state_d = WAIT;
`else
                state_d = memory_for_store ? STORE : BURST;
`endif
            end
`ifdef MEM_RESP_WAIT_EN
            WAIT: begin
                wcnt_d  = wcnt_q == WAIT_LAST ? '0 : wcnt_q + 1'b1;
                state_d = wcnt_q == WAIT_LAST ? run_state : WAIT;
            end
`endif
            BURST: begin
                cnt_d   = cnt_q == LAST_CNT ? '0 : cnt_q + 1'b1;
                state_d = cnt_q == LAST_CNT ? DONE : BURST;
            end
            STORE:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
`ifdef MEM_RESP_WAIT_EN
            wcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
`ifdef MEM_RESP_WAIT_EN
            wcnt_q  <= wcnt_d;
`endif
        end
        idx_q   <= idx_d;
        data_q  <= data_d;
        store_q <= store_d;
    end
    always_ff @(posedge clk) begin
        if (state_q == STORE && !rst) mem[idx_q] <= data_q;
        rdata_q <= mem[rd_idx];
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized scoreboard bench for mem_responder against a cycle-level request model
module tb_mem_responder;
    localparam int L  = 4;
    localparam int DL = 12;
`ifdef MEM_RESP_WAIT_EN
    localparam int W = 3;
`else
    localparam int W = 0;
`endif
    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        last;
    } beat_t;
    logic        clk, rst, memory_valid, memory_for_store, memory_ready, memory_last;
    logic [31:0] load_store_addr, data_to_mem, data_from_mem;
    int          cyc = 0;
    int          free = 0;
    int          vectors = 0;
    int          errs = 0;
    beat_t       sb[$];
    logic [31:0] ref_mem [int];

    mem_responder dut (
        .clk(clk), .rst(rst), .memory_valid(memory_valid), .memory_for_store(memory_for_store),
        .load_store_addr(load_store_addr), .data_to_mem(data_to_mem),
        .memory_ready(memory_ready), .memory_last(memory_last), .data_from_mem(data_from_mem)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (memory_ready) begin
            if (sb.size() == 0) chk("unexpected_beat", 32'd1, 32'd0);
            else begin
                e = sb.pop_front();
                chk("beat_cycle", 32'(cyc), 32'(e.cyc));
                chk("beat_data", data_from_mem, e.data);
                chk("beat_last", {31'd0, memory_last}, {31'd0, e.last});
            end
        end else begin
            chk("idle_outputs", {memory_last, data_from_mem[30:0]} | {31'd0, |data_from_mem}, 32'd0);
            if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                chk("missing_beat", 32'(cyc), 32'(sb[0].cyc));
                void'(sb.pop_front());
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mkaddr(input int idx);
        logic [31:0] r;
        r = $urandom();
        return (r << (DL + 2)) | (32'(idx) << 2) | (r & 32'd3);
    endfunction

    // abort_beat >= 0 pulses rst in the cycle after that read beat
    task automatic req(input bit st, input logic [31:0] a, input logic [31:0] d, input int abort_beat);
        int idx, base, acc, last_beat, ac;
        idx = int'(a[DL+1:2]);
        base = idx & ~(L - 1);
        memory_valid = 1;
        memory_for_store = st;
        load_store_addr = a;
        data_to_mem = d;
        acc = (cyc > free) ? cyc : free;
        if (st) begin
            sb.push_back('{acc + 1 + W, 32'd0, 1'b1});
            ref_mem[idx] = d;
            last_beat = acc + 1 + W;
            free = acc + 3 + W;
        end else begin
            for (int k = 0; k < L; k++)
                sb.push_back('{acc + 2 + W + k, ref_mem.exists(base + k) ? ref_mem[base + k] : 32'd0, k == L - 1});
            last_beat = acc + 1 + W + L;
            free = acc + 3 + W + L;
        end
        if (!st && abort_beat >= 0) begin
            ac = acc + 3 + W + abort_beat;
            while (cyc < ac) tick();
            rst = 1;
            memory_valid = 0;
            while (sb.size() > 0 && sb[$].cyc >= ac) void'(sb.pop_back());
            tick();
            rst = 0;
            free = cyc;
            return;
        end
        while (cyc < last_beat + 1) tick();
        memory_valid = 0;
    endtask

    function automatic int pick_word();
        return $urandom_range(0, 1) ? int'($urandom_range(0, 31)) : int'($urandom_range(4092, 4095));
    endfunction

    initial begin
        rst = 1;
        memory_valid = 0;
        memory_for_store = 0;
        load_store_addr = 0;
        data_to_mem = 0;
        repeat (3) tick();
        rst = 0;
        free = cyc;
        for (int i = 0; i < 32; i++) req(1, mkaddr(i), $urandom(), -1);
        for (int i = 4092; i < 4096; i++) req(1, mkaddr(i), $urandom(), -1);
        req(1, 32'h0000_0014, 32'hDEAD_BEEF, -1);
        tick();
        req(0, 32'h0000_0010, 32'd0, -1);
        repeat (2) tick();
        req(0, 32'h0000_001C, 32'd0, -1);
        req(0, mkaddr(8), 32'd0, -1);
        req(0, mkaddr(13), 32'd0, -1);
        tick();
        req(1, 32'h0000_3FFC, 32'h1234_5678, -1);
        req(0, 32'h0000_3FF0, 32'd0, -1);
        req(0, 32'h0000_0000, 32'd0, -1);
        tick();
        req(0, mkaddr(20), 32'd0, 1);
        repeat (2) tick();
        req(0, mkaddr(4), 32'd0, -1);
        for (int i = 0; i < 150; i++) begin
            req($urandom_range(0, 2) == 0, mkaddr(pick_word()), $urandom(), -1);
            if ($urandom_range(0, 1) != 0) repeat ($urandom_range(1, 3)) tick();
        end
        repeat (10) tick();
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 4, meaning words returned per read burst (power of two, at least 2).
REQ-002 SHALL have parameter DEPTH_LOG, default 12, meaning log2 of backing-store depth in words.
REQ-003 SHALL have parameter WAIT_CYCLES, default 3, meaning extra wait states inserted when MEM_RESP_WAIT_EN is defined (at least 1).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port memory_valid, input, 1, requester holds a request until its final memory_ready beat.
REQ-007 SHALL have port memory_for_store, input, 1, 1 = single-word store, 0 = line read.
REQ-008 SHALL have port load_store_addr, input, 32, byte address of the request.
REQ-009 SHALL have port data_to_mem, input, 32, store data.
REQ-010 SHALL have port memory_ready, output, 1, high for each completed beat.
REQ-011 SHALL have port memory_last, output, 1, high with the final beat of a request.
REQ-012 SHALL have port data_from_mem, output, 32, read beat data, valid while memory_ready is high on a read.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, BURST, STORE and DONE.
REQ-014 SHALL accept a request in IDLE when memory_valid=1, registering addr, data and for_store in that cycle (the accept cycle).
REQ-015 SHALL ignore memory_valid in every state other than IDLE.
REQ-016 SHALL form the word index as addr[DEPTH_LOG+1:2]; bits [1:0] are ignored, and upper bits beyond DEPTH_LOG+1 alias.
REQ-017 SHALL start a read burst at the line base (word index with its low log2(LINE_WORDS) bits cleared) and increment sequentially.
REQ-018 SHALL use a synchronous-read store with one cycle of read latency, so that read beat 0 has memory_ready=1 exactly 2 cycles after the accept cycle.
REQ-019 SHALL assert memory_ready on LINE_WORDS consecutive cycles for a read (state BURST) with no gaps, and assert memory_last only on beat LINE_WORDS-1.
REQ-020 SHALL, for a store, write data_to_mem to the word index and assert memory_ready and memory_last for exactly one cycle, 1 cycle after the accept cycle (state STORE).
REQ-021 SHALL spend exactly one cycle in DONE after the last beat, with memory_ready=0, then return to IDLE, giving the requester time to drop or replace memory_valid.
REQ-022 SHALL, for back-to-back requests, accept a request held high through DONE in the IDLE cycle that follows.
REQ-023 SHALL return, for a read issued after a store to the same word, the stored value.
REQ-024 SHALL hold data_from_mem at 0 whenever memory_ready=0 or the beat belongs to a store.
REQ-025 SHALL keep the address counter internal: a wrap at the store top wraps modulo 2^DEPTH_LOG.

Reset
REQ-026 SHALL, while rst=1, set the FSM to IDLE and drive memory_ready=0, memory_last=0, data_from_mem=0, and clear the beat and wait counters.
REQ-027 SHALL, on reset mid-burst or mid-wait, abort the request with no further beats and leave store contents unchanged, except for a store whose write cycle already completed.
REQ-028 SHALL NOT reset or clear the backing-store contents.

Configuration
REQ-029 SHALL, when MEM_RESP_WAIT_EN is defined, pass every accepted request through WAIT for WAIT_CYCLES cycles before BURST or STORE, so that read beat 0 arrives at accept+2+WAIT_CYCLES and the store beat at accept+1+WAIT_CYCLES.
REQ-030 SHALL, when MEM_RESP_WAIT_EN is undefined, never enter WAIT and remove the wait counter, giving the latencies in REQ-018 and REQ-020.

Verification
REQ-031 SHALL cover this store-then-read case: store 0xDEADBEEF to 0x0000_0014 with the macro off -> memory_ready+last at accept+1; then read of 0x0000_0010 -> beats at accept+2..+5, beat 1 = 0xDEADBEEF, last on beat 3.
REQ-032 SHALL cover this unaligned read: read of 0x0000_001C -> burst starts at word 4 (0x10), 4 beats, memory_last only on the 4th.
REQ-033 SHALL cover this back-to-back case: memory_valid held high across two reads -> exactly one idle DONE cycle between the bursts, and no beat is duplicated or dropped.
REQ-034 SHALL cover this mid-burst reset: rst pulsed after beat 1 -> memory_ready=0 from the next cycle, FSM in IDLE, and a new request served normally.
REQ-035 SHALL cover this wait-state case: with MEM_RESP_WAIT_EN defined and WAIT_CYCLES=3, a read -> beat 0 at accept+5, and a store -> ready at accept+4.
REQ-036 SHALL cover this address wrap: store at word index 2^DEPTH_LOG-1 then read of that line -> correct data, and word index 0 is unaffected.
